// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer with multi-cycle-op countdown FSM
// Optional PIPE_CTRL_STATS_EN adds saturating stall_cycles / flush_count outputs.
module pipe_ctrl #(
  parameter int MC_CNT_W = 6,
  parameter int ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles,
  input  logic                flush_req,
  input  logic [ADDR_W-1:0]   flush_pc,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [ADDR_W-1:0]   new_pc,
  output logic                mc_busy,
`ifdef PIPE_CTRL_STATS_EN
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count,
`endif
  output logic                mc_done
);

  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic {IDLE, MC_BUSY} state_t;

  state_t              state, state_n;
  logic [MC_CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = STALL_NONE;
    flush   = 1'b0;
    new_pc  = '0;
    mc_done = 1'b0;
    if (rst) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (flush_req) begin
      // Flush wins over everything and silently aborts any in-flight op.
      flush   = 1'b1;
      new_pc  = flush_pc;
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ex_mc_start && ex_mc_cycles != '0) begin
            stall = STALL_EX;
            if (ex_mc_cycles == MC_CNT_W'(1)) begin
              mc_done = 1'b1;
            end else begin
              cnt_n   = ex_mc_cycles - MC_CNT_W'(1);
              state_n = MC_BUSY;
            end
          end else begin
            stall = stallreq_id ? STALL_ID : STALL_NONE;
          end
        end
        MC_BUSY: begin
          // EX stall is a superset of the ID stall, so stallreq_id is moot here.
          stall = STALL_EX;
          cnt_n = cnt - MC_CNT_W'(1);
          if (cnt == MC_CNT_W'(1)) begin
            mc_done = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign mc_busy = !rst && (state == MC_BUSY);

`ifdef PIPE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall != STALL_NONE && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (flush && flush_count != 32'hFFFF_FFFF)
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule
